// File: rtl/tinyrv1_pkg.sv
// Shared types and constants for the tinyrv1 fetch front end.
package tinyrv1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } pcru_state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_plus4_adder.sv
// PC_W-bit +PC_INC incrementer; wraps modulo 2^PC_W with no carry out.
module pc_plus4_adder
  import tinyrv1_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] sum_o
);

  assign sum_o = pc_i + PC_W'(PC_INC);

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with bne/jump redirect, squash and halt handling.
// Optional branch statistics counters enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_unit
  import tinyrv1_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            eq_X,
  input  logic            br_en_X,
  input  logic [PC_W-1:0] br_targ_X,
  input  logic            jump_en_D,
  input  logic [PC_W-1:0] jump_targ_D,
  input  logic            stall_F,
  input  logic            halt_X,
  input  logic            imemreq_rdy,
  output logic            imemreq_val,
  output logic [PC_W-1:0] imemreq_addr,
  output logic [PC_W-1:0] pc_plus4_F,
  output logic            squash_D,
  output logic            halted
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [15:0]     br_total,
  output logic [15:0]     br_taken
`endif
);

  function automatic logic [PC_W-1:0] align_targ(input logic [PC_W-1:0] t);
    return {t[PC_W-1:2], 2'b00};
  endfunction

  pcru_state_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken;
  logic            transfer;
  logic            in_fetch;

  pc_plus4_adder #(.PC_W(PC_W)) u_inc (
    .pc_i  (pc_q),
    .sum_o (pc_plus4_F)
  );

  assign in_fetch     = (state_q == FETCH);
  assign taken        = br_en_X & ~eq_X;
  assign imemreq_val  = in_fetch & ~stall_F;
  assign transfer     = imemreq_val & imemreq_rdy;
  assign imemreq_addr = pc_q;
  assign squash_D     = in_fetch & taken;
  assign halted       = (state_q == HALT);

  // Branch beats jump beats sequential fetch; a taken branch also cancels a halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (taken)          pc_d = align_targ(br_targ_X);
        else if (jump_en_D) pc_d = align_targ(jump_targ_D);
        else if (transfer)  pc_d = pc_plus4_F;
        if (halt_X && !taken) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] br_total_q, br_taken_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else if (in_fetch) begin
      if (br_en_X) br_total_q <= sat_inc(br_total_q);
      if (taken)   br_taken_q <= sat_inc(br_taken_q);
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`endif

endmodule
